// File: rtl/game_pkg.sv
// Shared definitions for the brick-game controller: state codes and parameter defaults.
package game_pkg;

    // State codes are visible on the state output, so they are fixed explicitly.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StServe  = 3'd1,
        StPlay   = 3'd2,
        StLost   = 3'd3,
        StOver   = 3'd4,
        StWin    = 3'd5,
        StPaused = 3'd6
    } game_state_e;

    localparam int unsigned LIVES_INIT_DEF  = 3;
    localparam int unsigned SERVE_TICKS_DEF = 60;

endpackage

// File: rtl/serve_delay.sv
// Serve delay counter: counts tick pulses and flags the SERVE_TICKS-th one.
// done is combinational so the controller can leave SERVE on the very edge of that tick.
module serve_delay
    import game_pkg::*;
#(
    parameter int unsigned SERVE_TICKS = SERVE_TICKS_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int unsigned CntW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

    logic [CntW-1:0] cnt_q;
    logic            last;

    assign last = (cnt_q == CntW'(SERVE_TICKS - 1));
    assign done = tick & ~clear & last;

    // Count ticks while enabled; wrap to zero on the final tick.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Brick-game flow controller: serve, play, life loss, game over / win, optional pause.
// Optional pause support is enabled by defining GAME_PAUSE_EN.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT  = LIVES_INIT_DEF,
    parameter int unsigned SERVE_TICKS = SERVE_TICKS_DEF,
    parameter int unsigned SCORE_W     = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               tick,
    input  logic               miss,
    input  logic               brick_hit,
    input  logic               cleared,
    output logic               ball_rst,
    output logic               ball_run,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               endgame,
    output logic               win,
    output logic [2:0]         state
);

    game_state_e        state_q;
    logic               ball_rst_q;
    logic               ball_run_q;
    logic [1:0]         lives_q;
    logic [SCORE_W-1:0] score_q;
    logic               endgame_q;
    logic               win_q;
    logic               serve_done;

`ifndef GAME_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause;
`endif

    // Counter is held cleared outside SERVE so stray ticks never accumulate.
    serve_delay #(
        .SERVE_TICKS(SERVE_TICKS)
    ) u_serve_delay (
        .clock(clock),
        .reset(reset),
        .clear(state_q != StServe),
        .tick (tick),
        .done (serve_done)
    );

    // Game FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            ball_rst_q <= 1'b0;
            ball_run_q <= 1'b0;
            lives_q    <= 2'd0;
            score_q    <= '0;
            endgame_q  <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            ball_rst_q <= 1'b0;
            unique case (state_q)
                StIdle, StOver, StWin: begin
                    if (start) begin
                        state_q    <= StServe;
                        lives_q    <= 2'(LIVES_INIT);
                        score_q    <= '0;
                        ball_rst_q <= 1'b1;
                        ball_run_q <= 1'b0;
                        endgame_q  <= 1'b0;
                        win_q      <= 1'b0;
                    end
                end
                StServe: begin
                    if (serve_done) begin
                        state_q    <= StPlay;
                        ball_run_q <= 1'b1;
                    end
                end
                StPlay: begin
                    // Score counts even when the same cycle ends the rally.
                    if (brick_hit && (score_q != '1)) begin
                        score_q <= score_q + 1'b1;
                    end
                    if (cleared) begin
                        state_q    <= StWin;
                        ball_run_q <= 1'b0;
                        endgame_q  <= 1'b1;
                        win_q      <= 1'b1;
                    end else if (miss) begin
                        ball_run_q <= 1'b0;
                        if (lives_q > 2'd1) begin
                            lives_q    <= lives_q - 2'd1;
                            state_q    <= StLost;
                            ball_rst_q <= 1'b1;
                        end else begin
                            lives_q   <= 2'd0;
                            state_q   <= StOver;
                            endgame_q <= 1'b1;
                        end
                    end
`ifdef GAME_PAUSE_EN
                    else if (pause) begin
                        state_q    <= StPaused;
                        ball_run_q <= 1'b0;
                    end
`endif
                end
                StLost: begin
                    state_q <= StServe;
                end
                StPaused: begin
`ifdef GAME_PAUSE_EN
                    if (pause) begin
                        state_q    <= StPlay;
                        ball_run_q <= 1'b1;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ball_rst = ball_rst_q;
    assign ball_run = ball_run_q;
    assign lives    = lives_q;
    assign score    = score_q;
    assign endgame  = endgame_q;
    assign win      = win_q;
    assign state    = state_q;

endmodule
